// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame controller: FSM state
// encoding, error-cause codes and the frame header byte.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } rx_state_e;

  localparam logic [7:0] HEADER = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // States in which a frame is partially received and a byte is awaited.
  function automatic logic in_frame(input rx_state_e s);
    return (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: DEPTH x 8 register array, one synchronous
// write port and one asynchronous (combinational) read port. No reset; the
// controller never reads an entry it has not written in the current frame.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Write one payload byte per accepted receive strobe.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: parses HEADER(A5) LEN payload CSUM frames
// from a byte stream, checks length and 8-bit additive checksum, then drains
// the payload downstream over a valid/ready port.
// Optional feature: define UART_FRAME_TIMEOUT_EN to compile in the inter-byte
// timeout counter (error code 3); without it the FSM waits forever between
// bytes.
//
// Handshake: a payload byte transfers on every rising clock edge where
// o_pkt_valid && i_pkt_ready; while i_pkt_ready is low, o_pkt_valid,
// o_pkt_data and o_pkt_last stay stable, and once valid rises it only drops
// after the o_pkt_last byte transfers (or on reset).
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int MAX_LEN    = 16,
  parameter int TIMEOUT_US = 1000
) (
  input  logic       i_clk_sys,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic [7:0] o_pkt_data,
  output logic       o_pkt_valid,
  input  logic       i_pkt_ready,
  output logic       o_pkt_last,
  output logic [7:0] o_pkt_len,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  rx_state_e  state_q, state_d;
  logic [7:0] len_q,   len_d;
  logic [7:0] sum_q,   sum_d;
  logic [7:0] idx_q,   idx_d;
  logic       err_q,   err_d;
  logic [1:0] code_q,  code_d;
  logic       ovr_q,   ovr_d;

  logic       buf_we;
  logic [7:0] buf_rdata;
  logic [7:0] last_idx;
  logic       timeout_hit;

  assign last_idx = len_q - 8'd1;

  // idx_q is the write index while receiving and the read index while draining.
  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_i   (i_clk_sys),
    .we_i    (buf_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (i_rx_data),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam logic [31:0] TO_LIMIT = 32'(CLK_FRE * TIMEOUT_US - 1);

  logic [31:0] to_cnt_q, to_cnt_d;

  // Cycles since the last accepted byte; only runs while a frame is open.
  always_comb begin
    to_cnt_d = 32'd0;
    if (in_frame(state_q) && !i_rx_done) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      to_cnt_q <= 32'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // A byte arriving in the limit cycle wins: the FSM checks i_rx_done first.
  assign timeout_hit = in_frame(state_q) && (to_cnt_q == TO_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame parser next-state, datapath updates and error/overrun pulses.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    code_d  = code_q;
    ovr_d   = 1'b0;
    buf_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d = 8'd0;
        if (i_rx_done && (i_rx_data == HEADER)) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (i_rx_done) begin
          if ((i_rx_data == 8'd0) || (i_rx_data > MAX_LEN_B)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_BAD_LEN;
          end else begin
            len_d   = i_rx_data;
            sum_d   = i_rx_data;
            idx_d   = 8'd0;
            state_d = ST_PAYLOAD;
          end
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end

      ST_PAYLOAD: begin
        if (i_rx_done) begin
          buf_we = 1'b1;
          sum_d  = sum_q + i_rx_data;
          if (idx_q == last_idx) begin
            idx_d   = 8'd0;
            state_d = ST_CSUM;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end

      ST_CSUM: begin
        if (i_rx_done) begin
          if (i_rx_data == sum_q) begin
            idx_d   = 8'd0;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
          end
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end

      ST_DRAIN: begin
        // No room for a new frame until the buffer is empty; drop and flag.
        if (i_rx_done) begin
          ovr_d = 1'b1;
        end
        if (i_pkt_ready) begin
          if (idx_q == last_idx) begin
            idx_d   = 8'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      len_q   <= 8'd0;
      sum_q   <= 8'd0;
      idx_q   <= 8'd0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  // Data is forced to zero outside DRAIN so stale buffer contents never show.
  assign o_pkt_valid = (state_q == ST_DRAIN);
  assign o_pkt_data  = o_pkt_valid ? buf_rdata : 8'h00;
  assign o_pkt_last  = o_pkt_valid && (idx_q == last_idx);
  assign o_pkt_len   = len_q;
  assign o_frame_err = err_q;
  assign o_err_code  = code_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule
